// File: rtl/spi_rx_deser.sv
// Serial-to-parallel receiver: gathers bits qualified by bit_en into WIDTH-bit words with a valid/ready output.
// Optional even-parity framing is enabled by defining SPI_RX_DESER_PARITY_EN.
module spi_rx_deser #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             bit_en,
   input  logic             bit_in,
   input  logic             data_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             overrun,
   output logic             parity_err
);

   localparam int CW = $clog2(WIDTH + 1);
`ifdef SPI_RX_DESER_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_next;
   logic [WIDTH-1:0] word;
   logic             last_bit;
   logic             handshake;

   always_comb begin
      if (MSB_FIRST) shift_next = {shift_reg[WIDTH-2:0], bit_in};
      else           shift_next = {bit_in, shift_reg[WIDTH-1:1]};
   end

   assign last_bit  = (count == CW'(FRAME_LEN - 1));
   assign handshake = data_valid & data_ready;

`ifdef SPI_RX_DESER_PARITY_EN
   logic word_ok;
   // The parity bit never enters the shift register; it is only folded into the even-parity check.
   assign word    = shift_reg;
   assign word_ok = ~(^shift_reg ^ bit_in);
`else
   assign word       = shift_next;
   assign parity_err = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         shift_reg  <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
`ifdef SPI_RX_DESER_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         if (handshake) data_valid <= 1'b0;

         if (flush) begin
            state     <= IDLE;
            count     <= '0;
            shift_reg <= '0;
            overrun   <= 1'b0;
`ifdef SPI_RX_DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
         end else if (bit_en) begin
            if (last_bit) begin
               state     <= IDLE;
               count     <= '0;
               shift_reg <= '0;
`ifdef SPI_RX_DESER_PARITY_EN
               if (!word_ok) parity_err <= 1'b1;
               else
`endif
               if (data_valid && !handshake) begin
                  overrun <= 1'b1;
               end else begin
                  data_out   <= word;
                  data_valid <= 1'b1;
               end
            end else begin
               count     <= count + CW'(1);
               shift_reg <= (state == PARITY) ? shift_reg : shift_next;
               state     <= (count + CW'(1) == CW'(WIDTH)) ? PARITY : SHIFT;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed bench for spi_rx_deser: an MSB-first and an LSB-first instance share one bit stream.
// When SPI_RX_DESER_PARITY_EN is defined every frame carries an even-parity bit.
module tb_spi_rx_deser;

`ifdef SPI_RX_DESER_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic       clk = 1'b0;
   logic       rst_n, flush, bit_en, bit_in, data_ready;
   logic [7:0] data_out, lsb_data_out;
   logic       data_valid, overrun, parity_err;
   logic       lsb_valid, lsb_overrun, lsb_parity_err;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   spi_rx_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bit_en(bit_en), .bit_in(bit_in),
      .data_ready(data_ready), .data_out(data_out), .data_valid(data_valid),
      .overrun(overrun), .parity_err(parity_err)
   );

   spi_rx_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bit_en(bit_en), .bit_in(bit_in),
      .data_ready(data_ready), .data_out(lsb_data_out), .data_valid(lsb_valid),
      .overrun(lsb_overrun), .parity_err(lsb_parity_err)
   );

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bit i of a frame: data bits first-sent = seq[7], then the even-parity bit.
   function automatic logic frame_bit(input logic [7:0] seq, input int i);
      if (i < 8) return seq[7-i];
      return ^seq;
   endfunction

   task automatic send_frame(input logic [7:0] seq, input logic [7:0] hold, input string tag);
      for (int i = 0; i < NB; i++) begin
         bit_en = 1'b1;
         bit_in = frame_bit(seq, i);
         tick();
         if (i < NB - 1) begin
            checks++;
            if (data_out !== hold) begin errors++; $display("FAIL %s hold bit %0d: data_out %h expected %h", tag, i, data_out, hold); end
         end
      end
      bit_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({data_out, data_valid, overrun, parity_err} !== 11'd0) begin errors++; $display("FAIL reset outputs: got %h/%b/%b/%b expected 0", data_out, data_valid, overrun, parity_err); end
      checks++;
      if ({lsb_data_out, lsb_valid, lsb_overrun} !== 10'd0) begin errors++; $display("FAIL reset lsb outputs: got %h/%b/%b expected 0", lsb_data_out, lsb_valid, lsb_overrun); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_msb_word();
      data_ready = 1'b1;
      send_frame(8'hCA, 8'h00, "msb_word");
      checks++;
      if (data_out !== 8'hCA || data_valid !== 1'b1) begin errors++; $display("FAIL msb_word: got %h/%b expected ca/1", data_out, data_valid); end
      checks++;
      if (lsb_data_out !== 8'h53 || lsb_valid !== 1'b1) begin errors++; $display("FAIL lsb_word: got %h/%b expected 53/1", lsb_data_out, lsb_valid); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL msb_word overrun: got %b expected 0", overrun); end
      tick();
      checks++;
      if (data_valid !== 1'b0 || data_out !== 8'hCA) begin errors++; $display("FAIL msb_word consume: got %h/%b expected ca/0", data_out, data_valid); end
   endtask

   task automatic test_flush();
      bit_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bit_in = (i == 2);
         tick();
      end
      flush  = 1'b1;
      bit_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (data_out !== 8'hCA || lsb_data_out !== 8'h53) begin errors++; $display("FAIL flush hold %0d: got %h/%h expected ca/53", i, data_out, lsb_data_out); end
      end
      flush  = 1'b0;
      bit_en = 1'b0;
      send_frame(8'hA7, 8'hCA, "after_flush");
      checks++;
      if (data_out !== 8'hA7 || data_valid !== 1'b1) begin errors++; $display("FAIL after_flush: got %h/%b expected a7/1", data_out, data_valid); end
      checks++;
      if (lsb_data_out !== 8'hE5) begin errors++; $display("FAIL after_flush lsb: got %h expected e5", lsb_data_out); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (data_valid !== 1'b0 || data_out !== 8'hA7) begin errors++; $display("FAIL flush handshake: got %h/%b expected a7/0", data_out, data_valid); end
   endtask

   task automatic test_overrun();
      data_ready = 1'b0;
      send_frame(8'h3F, 8'hA7, "ovr_first");
      checks++;
      if (data_out !== 8'h3F || data_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: got %h/%b/%b expected 3f/1/0", data_out, data_valid, overrun); end
      checks++;
      if (lsb_data_out !== 8'hFC) begin errors++; $display("FAIL ovr_first lsb: got %h expected fc", lsb_data_out); end
      send_frame(8'hCA, 8'h3F, "ovr_second");
      checks++;
      if (data_out !== 8'h3F || data_valid !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_second: got %h/%b/%b expected 3f/1/1", data_out, data_valid, overrun); end
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      checks++;
      if (data_valid !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_consume: got valid %b overrun %b expected 0/1", data_valid, overrun); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (overrun !== 1'b0 || data_out !== 8'h3F) begin errors++; $display("FAIL ovr_flush: got %h overrun %b expected 3f/0", data_out, overrun); end
   endtask

   task automatic test_gaps();
      data_ready = 1'b1;
      for (int i = 0; i < NB; i++) begin
         bit_en = 1'b0;
         for (int g = 0; g < i % 3; g++) begin
            bit_in = ~bit_in;
            tick();
         end
         bit_en = 1'b1;
         bit_in = frame_bit(8'h6D, i);
         tick();
      end
      bit_en = 1'b0;
      checks++;
      if (data_out !== 8'h6D || lsb_data_out !== 8'hB6 || data_valid !== 1'b1) begin errors++; $display("FAIL gaps: got %h/%h/%b expected 6d/b6/1", data_out, lsb_data_out, data_valid); end
      tick();
   endtask

   task automatic test_back_to_back();
      data_ready = 1'b0;
      send_frame(8'h96, 8'h6D, "b2b_first");
      for (int i = 0; i < NB; i++) begin
         data_ready = (i == NB - 1);
         bit_en     = 1'b1;
         bit_in     = frame_bit(8'hCA, i);
         tick();
      end
      bit_en     = 1'b0;
      data_ready = 1'b0;
      checks++;
      if (data_out !== 8'hCA || data_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL back_to_back: got %h/%b/%b expected ca/1/0", data_out, data_valid, overrun); end
   endtask

   task automatic test_reset_mid();
      bit_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bit_in = (i != 1);
         tick();
      end
      bit_en = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({data_out, data_valid, overrun, parity_err, lsb_data_out} !== 19'd0) begin errors++; $display("FAIL reset_mid: got %h/%b/%b/%b lsb %h expected all 0", data_out, data_valid, overrun, parity_err, lsb_data_out); end
      @(negedge clk);
      rst_n      = 1'b1;
      data_ready = 1'b1;
      send_frame(8'hF0, 8'h00, "after_reset");
      checks++;
      if (data_out !== 8'hF0 || lsb_data_out !== 8'h0F || data_valid !== 1'b1) begin errors++; $display("FAIL after_reset: got %h/%h/%b expected f0/0f/1", data_out, lsb_data_out, data_valid); end
      tick();
   endtask

`ifdef SPI_RX_DESER_PARITY_EN
   task automatic test_parity();
      data_ready = 1'b1;
      for (int i = 0; i < NB; i++) begin
         bit_en = 1'b1;
         bit_in = (i < 8) ? frame_bit(8'hCA, i) : 1'b1;
         tick();
      end
      bit_en = 1'b0;
      checks++;
      if (data_out !== 8'hF0 || data_valid !== 1'b0 || parity_err !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL parity_bad: got %h/%b/%b/%b expected f0/0/1/0", data_out, data_valid, parity_err, overrun); end
      for (int i = 0; i < NB; i++) begin
         bit_en = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
         bit_en = 1'b1;
         bit_in = frame_bit(8'hCA, i);
         tick();
      end
      bit_en = 1'b0;
      checks++;
      if (data_out !== 8'hCA || data_valid !== 1'b1 || parity_err !== 1'b1) begin errors++; $display("FAIL parity_good_gaps: got %h/%b/%b expected ca/1/1", data_out, data_valid, parity_err); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_flush: got %b expected 0", parity_err); end
   endtask
`else
   task automatic test_parity();
      checks++;
      if (parity_err !== 1'b0 || lsb_parity_err !== 1'b0) begin errors++; $display("FAIL parity_tied: got %b/%b expected 0/0", parity_err, lsb_parity_err); end
   endtask
`endif

   initial begin
      flush      = 1'b0;
      bit_en     = 1'b0;
      bit_in     = 1'b0;
      data_ready = 1'b1;
      test_reset();
      test_msb_word();
      test_flush();
      test_overrun();
      test_gaps();
      test_back_to_back();
      test_reset_mid();
      test_parity();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
